// File: rtl/mac_tx.sv
// Ethernet MAC transmit framer: byte stream in, 4-bit nibble PHY stream out.
// Adds preamble/SFD, zero-pads short frames, appends CRC-32 FCS, then holds the inter-frame gap.
module mac_tx #(
    parameter int MIN_FRAME        = 60,
    parameter int IFG_NIBBLES      = 24,
    parameter int PREAMBLE_NIBBLES = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [3:0] txd,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_ABORT,
        S_IFG
    } state_t;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam int CNT_MAX  = (IFG_NIBBLES > PREAMBLE_NIBBLES) ? IFG_NIBBLES : PREAMBLE_NIBBLES;
    localparam int CNT_W    = $clog2(((CNT_MAX > 8) ? CNT_MAX : 8) + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIBBLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);
    localparam logic [11:0]      MIN_LEN  = 12'(MIN_FRAME);

    // r_state names what is on the wire this cycle; the output registers are
    // loaded from the next-state decode so the PHY sees a nibble one edge after the decision.
    state_t           r_state;
    logic             r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_hold_data;
    logic             r_hold_last;
    logic [10:0]      r_byte_cnt;
    logic [31:0]      r_crc;

    state_t           w_nxt_state;
    logic             w_nxt_phase;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [3:0]       w_nxt_txd;
    logic             w_nxt_en;
    logic             w_nxt_er;
    logic             w_nxt_done;
    logic             w_nxt_under;
    logic             w_capture;
    logic             w_byte_step;
    logic             w_crc_upd;
    logic [3:0]       w_crc_nib;
    logic [31:0]      w_crc_base;
    logic [31:0]      w_fcs;
    logic [2:0]       w_fcs_idx;
    logic [10:0]      w_byte_inc;
    logic             w_pad_more;

    function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            c = (c >> 1) ^ (((c[0] ^ nib[i]) != 1'b0) ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    assign w_byte_inc = (r_byte_cnt == 11'h7FF) ? r_byte_cnt : r_byte_cnt + 11'd1;
    assign w_pad_more = ({1'b0, w_byte_inc} < MIN_LEN);
    assign w_crc_base = (r_state == S_SFD) ? 32'hFFFF_FFFF : r_crc;
    assign w_fcs      = ~r_crc;
    assign w_fcs_idx  = r_cnt[2:0] + 3'd1;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_nxt_state = r_state;
        w_nxt_phase = r_phase;
        w_nxt_cnt   = r_cnt;
        w_nxt_txd   = 4'h0;
        w_nxt_en    = 1'b0;
        w_nxt_er    = 1'b0;
        w_nxt_done  = 1'b0;
        w_nxt_under = 1'b0;
        w_capture   = 1'b0;
        w_byte_step = 1'b0;
        w_crc_upd   = 1'b0;
        w_crc_nib   = 4'h0;
        in_ready    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_nxt_state = S_PREAMBLE;
                    w_nxt_cnt   = '0;
                    w_nxt_txd   = 4'h5;
                    w_nxt_en    = 1'b1;
                end
            end

            S_PREAMBLE: begin
                w_nxt_en = 1'b1;
                if (r_cnt == PRE_LAST) begin
                    w_nxt_state = S_SFD;
                    w_nxt_txd   = 4'hD;
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                    w_nxt_txd = 4'h5;
                end
            end

            S_SFD: begin
                in_ready = 1'b1;
                w_nxt_en = 1'b1;
                if (in_valid) begin
                    w_capture   = 1'b1;
                    w_nxt_state = S_DATA;
                    w_nxt_phase = 1'b0;
                    w_nxt_txd   = in_data[3:0];
                    w_crc_upd   = 1'b1;
                    w_crc_nib   = in_data[3:0];
                end else begin
                    w_nxt_state = S_ABORT;
                    w_nxt_er    = 1'b1;
                    w_nxt_under = 1'b1;
                end
            end

            S_DATA: begin
                w_nxt_en = 1'b1;
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                    w_nxt_txd   = r_hold_data[7:4];
                    w_crc_upd   = 1'b1;
                    w_crc_nib   = r_hold_data[7:4];
                end else begin
                    in_ready    = !r_hold_last;
                    w_byte_step = 1'b1;
                    if (r_hold_last) begin
                        if (w_pad_more) begin
                            w_nxt_state = S_PAD;
                            w_nxt_phase = 1'b0;
                            w_crc_upd   = 1'b1;
                        end else begin
                            w_nxt_state = S_FCS;
                            w_nxt_cnt   = '0;
                            w_nxt_txd   = w_fcs[3:0];
                        end
                    end else if (in_valid) begin
                        w_capture   = 1'b1;
                        w_nxt_phase = 1'b0;
                        w_nxt_txd   = in_data[3:0];
                        w_crc_upd   = 1'b1;
                        w_crc_nib   = in_data[3:0];
                    end else begin
                        w_nxt_state = S_ABORT;
                        w_nxt_er    = 1'b1;
                        w_nxt_under = 1'b1;
                    end
                end
            end

            S_PAD: begin
                w_nxt_en = 1'b1;
                if (!r_phase) begin
                    w_nxt_phase = 1'b1;
                    w_crc_upd   = 1'b1;
                end else begin
                    w_byte_step = 1'b1;
                    if (w_pad_more) begin
                        w_nxt_phase = 1'b0;
                        w_crc_upd   = 1'b1;
                    end else begin
                        w_nxt_state = S_FCS;
                        w_nxt_cnt   = '0;
                        w_nxt_txd   = w_fcs[3:0];
                    end
                end
            end

            S_FCS: begin
                if (r_cnt[2:0] == 3'd7) begin
                    w_nxt_state = S_IFG;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt  = r_cnt + 1'b1;
                    w_nxt_en   = 1'b1;
                    w_nxt_txd  = w_fcs[{w_fcs_idx, 2'b00} +: 4];
                    w_nxt_done = (r_cnt[2:0] == 3'd6);
                end
            end

            S_ABORT: begin
                w_nxt_state = S_IFG;
                w_nxt_cnt   = '0;
            end

            S_IFG: begin
                // A waiting frame starts straight from the last gap cycle so the gap is exact.
                if (r_cnt == IFG_LAST) begin
                    if (in_valid) begin
                        w_nxt_state = S_PREAMBLE;
                        w_nxt_cnt   = '0;
                        w_nxt_txd   = 4'h5;
                        w_nxt_en    = 1'b1;
                    end else begin
                        w_nxt_state = S_IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_phase     <= 1'b0;
            r_cnt       <= '0;
            r_hold_data <= 8'h00;
            r_hold_last <= 1'b0;
            r_byte_cnt  <= 11'd0;
            r_crc       <= 32'hFFFF_FFFF;
            txd         <= 4'h0;
            tx_en       <= 1'b0;
            tx_er       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_state    <= w_nxt_state;
            r_phase    <= w_nxt_phase;
            r_cnt      <= w_nxt_cnt;
            txd        <= w_nxt_txd;
            tx_en      <= w_nxt_en;
            tx_er      <= w_nxt_er;
            busy       <= (w_nxt_state != S_IDLE);
            frame_done <= w_nxt_done;
            underrun   <= w_nxt_under;
            r_crc      <= w_crc_upd ? crc_nibble(w_crc_base, w_crc_nib) : w_crc_base;
            if (w_capture) begin
                r_hold_data <= in_data;
                r_hold_last <= in_last;
            end
            if (r_state == S_SFD) begin
                r_byte_cnt <= 11'd0;
            end else if (w_byte_step) begin
                r_byte_cnt <= w_byte_inc;
            end
        end
    end

endmodule
